// File: rtl/serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// serial_adder_ctrl
//
// Purpose: adds (or subtracts) two WIDTH-bit operands four bits per clock.
// A single 4-bit adder slice is reused: each RUN cycle processes one nibble,
// least significant first. The carry between slices is held in a register.
// Subtraction is done as a + ~b + 1.
//
// Ports:
//   clk      - system clock, rising edge
//   rst      - asynchronous, active-high reset
//   start    - request pulse, accepted in IDLE or DONE
//   sub      - 0 = add, 1 = subtract (a - b); sampled at accept
//   carry_in - initial carry for add (ignored for subtract); sampled at accept
//   a, b     - operands; sampled at accept
//   busy     - high while an operation is in progress
//   done     - one-cycle completion strobe
//   sum      - result register, updated only on completion
//   overflow - carry out of the most significant slice (for subtract:
//              1 = no borrow), updated only on completion
// ---------------------------------------------------------------------------
module serial_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic             carry_in,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             overflow
);

  localparam int N    = WIDTH / 4;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              carry_q, carry_d;
  logic [WIDTH-1:0]  work_q, work_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              overflow_q, overflow_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [3:0]        a_slice;
  logic [3:0]        b_slice;
  logic [4:0]        slice_res;

  // Select the current nibble of each operand and run it through the
  // shared 4-bit adder slice together with the registered carry.
  always_comb begin
    a_slice = '0;
    b_slice = '0;
    for (int i = 0; i < N; i++) begin
      if (idx_q == IDXW'(i)) begin
        a_slice = a_q[4*i +: 4];
        b_slice = b_q[4*i +: 4];
      end
    end
    slice_res = {1'b0, a_slice} + {1'b0, b_slice} + {4'b0000, carry_q};
  end

  // Next-state logic for the sequencer and its datapath registers.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    carry_d    = carry_q;
    work_d     = work_q;
    a_d        = a_q;
    b_d        = b_q;
    sum_d      = sum_q;
    overflow_d = overflow_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          // Subtraction is a + ~b + 1, so the initial carry is forced to 1.
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : carry_in;
          idx_d   = '0;
          work_d  = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        for (int i = 0; i < N; i++) begin
          if (idx_q == IDXW'(i)) begin
            work_d[4*i +: 4] = slice_res[3:0];
          end
        end
        carry_d = slice_res[4];
        idx_d   = idx_q + IDXW'(1);
        if (idx_q == LAST_IDX) begin
          // work_d already holds the slice just computed.
          sum_d      = work_d;
          overflow_d = slice_res[4];
          state_d    = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Status outputs are registered from the next state so they line up
    // with the state they describe.
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      carry_q    <= 1'b0;
      work_q     <= '0;
      a_q        <= '0;
      b_q        <= '0;
      sum_q      <= '0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      carry_q    <= carry_d;
      work_q     <= work_d;
      a_q        <= a_d;
      b_q        <= b_d;
      sum_q      <= sum_d;
      overflow_q <= overflow_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign sum      = sum_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_adder_ctrl
//
// Self-checking bench for serial_adder_ctrl (WIDTH = 16). Accepted requests
// push their expected {overflow, sum} into a queue; every done strobe pops
// and compares.
// ---------------------------------------------------------------------------
module tb_serial_adder_ctrl;

  localparam int WIDTH = 16;

  logic             clk;
  logic             rst;
  logic             start;
  logic             sub;
  logic             carry_in;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             overflow;

  int checkCount = 0;
  int failCount  = 0;
  int doneCount  = 0;

  logic [WIDTH:0] expQueue[$];

  serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .sub      (sub),
    .carry_in (carry_in),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .overflow (overflow)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every comparison goes through here.
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: {overflow, sum}.
  function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] ta,
                                           input logic [WIDTH-1:0] tb,
                                           input logic tsub, input logic tcin);
    logic [WIDTH:0] r;
    if (tsub) r = {1'b0, ta} + {1'b0, ~tb} + (WIDTH+1)'(1);
    else      r = {1'b0, ta} + {1'b0, tb} + {{WIDTH{1'b0}}, tcin};
    return r;
  endfunction

  // Scoreboard: compare result at every done strobe.
  always @(negedge clk) begin
    if (!rst && done) begin
      doneCount++;
      checkOutput("busy_at_done", {31'd0, busy}, 32'd0);
      if (expQueue.size() == 0) begin
        checkOutput("unexpected_done", 32'd1, 32'd0);
      end else begin
        logic [WIDTH:0] e;
        e = expQueue.pop_front();
        checkOutput("sum", {16'd0, sum}, {16'd0, e[WIDTH-1:0]});
        checkOutput("overflow", {31'd0, overflow}, {31'd0, e[WIDTH]});
      end
    end
  end

  // Drive a start pulse (called #1 after a rising edge); returns #1 after
  // the accept edge.
  task automatic applyStimulus(input logic [WIDTH-1:0] ta,
                               input logic [WIDTH-1:0] tb,
                               input logic tsub, input logic tcin,
                               input bit push);
    a = ta; b = tb; sub = tsub; carry_in = tcin; start = 1'b1;
    if (push) expQueue.push_back(model(ta, tb, tsub, tcin));
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Wait (bounded) for done; reports negedges waited and busy cycles seen.
  task automatic waitDone(output int iters, output int busyCnt);
    iters = 0;
    busyCnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      iters++;
      if (done) return;
      if (busy) busyCnt++;
    end
    checkOutput("done_timeout", 32'd0, 32'd1);
  endtask

  // Full single operation with latency and strobe-width checks.
  task automatic runOp(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                       input logic tsub, input logic tcin);
    int iters, busyCnt;
    applyStimulus(ta, tb, tsub, tcin, 1'b1);
    waitDone(iters, busyCnt);
    checkOutput("done_latency", iters, 32'd5);
    checkOutput("busy_cycles", busyCnt, 32'd4);
    @(negedge clk);
    checkOutput("done_width", {31'd0, done}, 32'd0);
    checkOutput("idle_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int iters, busyCnt, d0;
    logic [WIDTH:0] e;

    rst = 1'b1; start = 1'b0; sub = 1'b0; carry_in = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_sum", {16'd0, sum}, 32'd0);
    checkOutput("rst_overflow", {31'd0, overflow}, 32'd0);
    @(posedge clk); #1;

    // Directed cases
    runOp(16'h1234, 16'h0FCD, 1'b0, 1'b0);
    runOp(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    runOp(16'hFFFF, 16'h0000, 1'b0, 1'b1);
    runOp(16'h0005, 16'h0007, 1'b1, 1'b1);
    runOp(16'h0007, 16'h0005, 1'b1, 1'b0);

    // Result must hold while idle.
    repeat (3) @(negedge clk);
    checkOutput("sum_hold", {16'd0, sum}, 32'h0002);
    checkOutput("overflow_hold", {31'd0, overflow}, 32'd1);
    @(posedge clk); #1;

    // Random cases
    for (int i = 0; i < 8; i++) begin
      runOp(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    end

    // Start during RUN must be ignored.
    d0 = doneCount;
    applyStimulus(16'h1234, 16'h0FCD, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    a = 16'h1111; b = 16'h1111; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    waitDone(iters, busyCnt);
    checkOutput("ignored_start_latency", iters, 32'd3);
    repeat (10) @(negedge clk);
    checkOutput("no_extra_done", doneCount - d0, 32'd1);
    checkOutput("back_to_idle", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;

    // Back-to-back: start held through DONE.
    a = 16'h1234; b = 16'h0FCD; sub = 1'b0; carry_in = 1'b0; start = 1'b1;
    expQueue.push_back(model(16'h1234, 16'h0FCD, 1'b0, 1'b0));
    @(posedge clk); #1;
    a = 16'h0100; b = 16'h0200;
    expQueue.push_back(model(16'h0100, 16'h0200, 1'b0, 1'b0));
    waitDone(iters, busyCnt);
    @(posedge clk); #1;
    start = 1'b0;
    waitDone(iters, busyCnt);
    checkOutput("b2b_spacing", iters, 32'd5);
    checkOutput("b2b_busy_cycles", busyCnt, 32'd4);
    @(posedge clk); #1;
    repeat (2) @(posedge clk);
    #1;

    // Reset during slice 2 of 0xFFFF + 0x0001.
    applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
    checkOutput("midrst_sum", {16'd0, sum}, 32'd0);
    checkOutput("midrst_overflow", {31'd0, overflow}, 32'd0);
    d0 = doneCount;
    @(posedge clk);
    #3 rst = 1'b0;
    repeat (8) @(negedge clk);
    checkOutput("no_done_after_rst", doneCount - d0, 32'd0);
    @(posedge clk); #1;
    runOp(16'h0001, 16'h0001, 1'b0, 1'b0);

    checkOutput("queue_drained", expQueue.size(), 32'd0);
    e = model(16'h0001, 16'h0001, 1'b0, 1'b0);
    checkOutput("final_sum", {16'd0, sum}, {16'd0, e[WIDTH-1:0]});

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
